// File: rtl/iot_event_pkg.sv
// Shared definitions for the IoT event queue.
// Holds the change-code values, channel identifiers and the layout of
// the event record {ts, ch, code}, plus a small channel-rotation helper.
package iot_event_pkg;

    // Change codes carried in each 2-bit field of the detector word
    localparam logic [1:0] EV_NONE  = 2'b00;
    localparam logic [1:0] EV_RISE  = 2'b01;
    localparam logic [1:0] EV_FALL  = 2'b10;
    localparam logic [1:0] EV_FAULT = 2'b11;

    // Channel identifiers (field index inside the detector word)
    localparam int         NUM_CH    = 3;
    localparam logic [1:0] CH_LIGHTS = 2'd0;
    localparam logic [1:0] CH_PLUGS  = 2'd1;
    localparam logic [1:0] CH_TEMP   = 2'd2;

    // Event record layout, LSB first: code, then channel, then timestamp
    localparam int CODE_W   = 2;
    localparam int CH_W     = 2;
    localparam int CODE_LSB = 0;
    localparam int CH_LSB   = CODE_LSB + CODE_W;
    localparam int TS_LSB   = CH_LSB + CH_W;

    // Next channel in round-robin order, wrapping 2 -> 0
    function automatic logic [1:0] next_ch(input logic [1:0] c);
        return (c == CH_TEMP) ? CH_LIGHTS : c + 2'd1;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word fall-through FIFO for event records.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   push, push_data  write request and record (ignored when full)
//   pop              read request (ignored when empty)
//   head             oldest entry, forced to zero while empty
//   full, empty      occupancy flags
//   level            number of stored entries (0..DEPTH)
module event_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   LVL_ONE = 1;
    localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == LVL_MAX);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; stale contents are masked by 'empty'
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head  = empty ? '0 : mem[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/iot_event_queue.sv
// Timestamps change events from the IoT change detector, arbitrates
// simultaneous events round-robin and queues them as records.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   data       three 2-bit change codes (lights, plugs, temperature)
//   ev_data    head record {ts, ch, code}; ev_valid flags it, ev_ready pops it
//   level      queue occupancy
//   drop_cnt   saturating count of events lost to a busy pending slot
//   overflow   sticky flag, set on the first lost event
module iot_event_queue
    import iot_event_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               data,
    output logic [TS_W+3:0]          ev_data,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     overflow
);

    localparam logic [TS_W-1:0] TS_ONE = 1;

    logic [TS_W-1:0]                   ts_q, ts_d;
    logic [NUM_CH-1:0]                 pending_q, pending_d;
    logic [NUM_CH-1:0][CODE_W-1:0]     slot_code_q, slot_code_d;
    logic [NUM_CH-1:0][TS_W-1:0]       slot_ts_q, slot_ts_d;
    logic [1:0]                        rr_q, rr_d;
    logic [DROP_W-1:0]                 drop_cnt_q, drop_cnt_d;
    logic                              overflow_q, overflow_d;

    logic [NUM_CH-1:0][CODE_W-1:0]     code_w;
    logic [NUM_CH-1:0]                 granted, load, drop_hit;
    logic                              grant_vld;
    logic [1:0]                        grant_ch, cand;
    logic [DROP_W:0]                   drop_sum;
    logic [TS_W+3:0]                   push_data;
    logic                              fifo_full, fifo_empty;

    // Round-robin search from rr; no grant while the queue is full so a
    // pending event simply waits in its slot for a free entry.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = rr_q;
        cand      = rr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!grant_vld && !fifo_full && pending_q[cand]) begin
                grant_vld = 1'b1;
                grant_ch  = cand;
            end
            cand = next_ch(cand);
        end
    end

    // Per-channel capture. A granted slot empties this edge, so a new
    // event on that channel may reload it instead of being dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign code_w[gi]    = data[CODE_W*gi +: CODE_W];
            assign granted[gi]   = grant_vld && (grant_ch == 2'(gi));
            assign load[gi]      = (code_w[gi] != EV_NONE) && (!pending_q[gi] || granted[gi]);
            assign drop_hit[gi]  = (code_w[gi] != EV_NONE) && pending_q[gi] && !granted[gi];
            assign pending_d[gi] = load[gi] || (pending_q[gi] && !granted[gi]);
        end
    endgenerate

    always_comb begin
        slot_code_d = slot_code_q;
        slot_ts_d   = slot_ts_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load[i]) begin
                slot_code_d[i] = code_w[i];
                slot_ts_d[i]   = ts_q;
            end
        end
        ts_d       = ts_q + TS_ONE;
        rr_d       = grant_vld ? next_ch(grant_ch) : rr_q;
        // Several channels can collide on one edge; count each loss
        drop_sum   = {1'b0, drop_cnt_q} + (DROP_W+1)'($countones(drop_hit));
        drop_cnt_d = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
        overflow_d = overflow_q || (|drop_hit);
        push_data  = {slot_ts_q[grant_ch], grant_ch, slot_code_q[grant_ch]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q        <= '0;
            pending_q   <= '0;
            slot_code_q <= '0;
            slot_ts_q   <= '0;
            rr_q        <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            ts_q        <= ts_d;
            pending_q   <= pending_d;
            slot_code_q <= slot_code_d;
            slot_ts_q   <= slot_ts_d;
            rr_q        <= rr_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    event_fifo #(
        .WIDTH (TS_W + 4),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_vld),
        .push_data (push_data),
        .pop       (ev_ready),
        .head      (ev_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign ev_valid = !fifo_empty;
    assign drop_cnt = drop_cnt_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_iot_event_queue.sv
module tb_iot_event_queue;
    import iot_event_pkg::*;

    localparam int DEPTH  = 8;
    localparam int TS_W   = 4;
    localparam int DROP_W = 3;
    localparam int RW     = TS_W + 4;
    localparam int DMAX   = (1 << DROP_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [5:0]               data = '0;
    logic                     ev_ready = 1'b0;
    logic [RW-1:0]            ev_data;
    logic                     ev_valid;
    logic [$clog2(DEPTH):0]   level;
    logic [DROP_W-1:0]        drop_cnt;
    logic                     overflow;

    int n_tests = 0;
    int n_fail  = 0;

    iot_event_queue #(.DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .ev_data  (ev_data),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .level    (level),
        .drop_cnt (drop_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Channels hold at most one waiting event each; the queue is a plain
    // list of expected records. Evaluated once per clock edge.
    bit            m_pend [3];
    logic [1:0]    m_code [3];
    int            m_tsv  [3];
    int            m_ts    = 0;
    int            m_rr    = 0;
    int            m_level = 0;
    int            m_drops = 0;
    logic [RW-1:0] exp_q [$];

    always @(posedge clk or negedge rst) begin
        int g;
        int c;
        logic [1:0] code;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_pend[i] = 0;
                m_code[i] = 2'b00;
                m_tsv[i]  = 0;
            end
            m_ts = 0; m_rr = 0; m_level = 0; m_drops = 0;
            exp_q.delete();
        end else begin
            g = -1;
            if (m_level < DEPTH) begin
                for (int k = 0; k < 3; k++) begin
                    c = (m_rr + k) % 3;
                    if (g < 0 && m_pend[c]) g = c;
                end
            end
            if (m_level > 0 && ev_ready) m_level--;
            if (g >= 0) begin
                exp_q.push_back({TS_W'(m_tsv[g]), 2'(g), m_code[g]});
                m_level++;
                m_pend[g] = 0;
                m_rr = (g + 1) % 3;
            end
            for (int i = 0; i < 3; i++) begin
                code = data[2*i +: 2];
                if (code != EV_NONE) begin
                    if (!m_pend[i]) begin
                        m_pend[i] = 1;
                        m_code[i] = code;
                        m_tsv[i]  = m_ts;
                    end else begin
                        m_drops++;
                    end
                end
            end
            m_ts = (m_ts + 1) % (1 << TS_W);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("level", int'(level), m_level);
            check("ev_valid", int'(ev_valid), int'(m_level != 0));
            check("drop_cnt", int'(drop_cnt), (m_drops > DMAX) ? DMAX : m_drops);
            check("overflow", int'(overflow), int'(m_drops > 0));
            if (ev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_record", int'(ev_data), -1);
                end else begin
                    check("ev_data", int'(ev_data), int'(exp_q[0]));
                    if (ev_ready) begin
                        $display("[TB] pop ts=%0d ch=%0d code=%0d", ev_data[RW-1:TS_LSB],
                                 ev_data[CH_LSB +: CH_W], ev_data[CODE_LSB +: CODE_W]);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges and checks the asynchronous clear
    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_ev_valid", int'(ev_valid), 0);
        check("rst_level", int'(level), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        check("rst_ev_data", int'(ev_data), 0);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        logic [5:0] w;
        tick(2);
        check("init_ev_valid", int'(ev_valid), 0);
        check("init_level", int'(level), 0);
        check("init_ev_data", int'(ev_data), 0);
        check("init_overflow", int'(overflow), 0);
        rst = 1'b1;

        // single event on lights
        ev_ready = 1'b1;
        data = {4'b0000, EV_RISE};
        tick(1);
        data = '0;
        tick(1);
        check("single_valid", int'(ev_valid), 1);
        check("single_ch_code", int'(ev_data[3:0]), int'({CH_LIGHTS, EV_RISE}));
        tick(3);
        check("single_level_after", int'(level), 0);

        // simultaneous events, rr starts at 0
        do_reset();
        data = 6'b100110;
        tick(1);
        data = '0;
        tick(6);

        // back-to-back events on temp while granted
        data = {EV_FAULT, 4'b0000};
        tick(2);
        data = '0;
        tick(5);
        check("collision_drop", int'(drop_cnt), 0);

        // backpressure on plugs
        do_reset();
        ev_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            data = {2'b00, EV_FALL, 2'b00};
            tick(1);
            data = '0;
            tick(2);
        end
        check("bp_level", int'(level), DEPTH);
        check("bp_drop", int'(drop_cnt), 1);
        check("bp_overflow", int'(overflow), 1);
        tick(4);
        ev_ready = 1'b1;
        tick(15);

        // reset mid-stream, then a fresh event gets ts 0
        ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data = {4'b0000, EV_FAULT};
            tick(1);
            data = '0;
            tick(1);
        end
        do_reset();
        ev_ready = 1'b1;
        data = {EV_FAULT, 4'b0000};
        tick(1);
        data = '0;
        tick(1);
        check("post_rst_record", int'(ev_data), int'({4'd0, CH_TEMP, EV_FAULT}));
        tick(4);

        // randomized traffic with alternating stall-heavy windows
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                w[2*i +: 2] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
            data = w;
            if (((cyc / 200) % 2) == 0)
                ev_ready = ($urandom_range(0, 3) != 0);
            else
                ev_ready = ($urandom_range(0, 3) == 0);
            tick(1);
        end

        // drain
        data = '0;
        ev_ready = 1'b1;
        tick(40);
        check("drain_empty", exp_q.size(), 0);
        check("drain_level", int'(level), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iot_event_queue.md
Name: iot_event_queue

Overview:
- Downstream consumer of the IoT change-detector word `data[5:0]`.
- Each field carries a 2-bit change code for one channel: bits 1:0 lights (ch 0), 3:2 plugs (ch 1), 5:4 temperature (ch 2).
- The block timestamps every non-zero code, arbitrates simultaneous events round-robin and buffers them in a FIFO.
- Events leave as records on a valid/ready stream for the reporting/transmit stage.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- TS_W, 16, free-running timestamp width in bits.
- DROP_W, 8, width of the saturating dropped-event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- data  in  6  change codes from the change detector, sampled every clk.
- ev_data  out  TS_W+4  event record {ts[TS_W-1:0], ch[1:0], code[1:0]}.
- ev_valid  out  1  ev_data holds the FIFO head.
- ev_ready  in  1  consumer accepts the head this cycle.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- drop_cnt  out  DROP_W  events lost to pending-slot collision, saturating.
- overflow  out  1  sticky; set on the first drop.

Behaviour:
- Codes:
  - 00 no change, ignored.
  - 01 rose, 10 fell, 11 fault; all non-zero codes are forwarded unmodified.
- Reset (rst=0, async): ts, pending[2:0], rr pointer, FIFO pointers, level, drop_cnt and overflow go to 0; ev_valid=0; ev_data=0.
- Timestamp: ts increments every clk and wraps from 2^TS_W-1 to 0.
- Capture stage, per channel i, at each edge:
  - If code_i!=0 and pending[i]=0: set pending[i]; store code_i and the current ts.
  - If code_i!=0, pending[i]=1 and channel i is granted this same edge: reload the slot with the new code/ts; pending stays 1; no drop.
  - If code_i!=0, pending[i]=1 and channel i is not granted: new event discarded, old slot kept, drop_cnt+1 (saturates at 2^DROP_W-1), overflow<=1.
- Arbiter:
  - Grants one pending channel per cycle, only when the FIFO is not full.
  - Search starts at rr, in order rr, rr+1, rr+2 mod 3; rr then moves to granted+1 mod 3.
  - A grant pushes {ts_i, i, code_i} and clears pending[i] (unless reloaded as above).
- FIFO:
  - First-word fall-through: ev_valid = (level!=0) and ev_data = head.
  - Pop when ev_valid && ev_ready.
  - Push and pop on the same edge leave level unchanged.
  - When full, no grant is issued (no pass-through); a pop frees the slot and the grant happens next cycle.
  - Empty with ev_ready=1: nothing happens.
- Latency, empty queue and no contention: data valid before edge k, pending set at k, pushed at k+1, ev_valid=1 after k+1. The recorded ts is the value at edge k.
- Handshake: ev_data stays stable while ev_valid=1 and ev_ready=0.
- Reset mid-operation: all queued and pending events are lost; outputs return to reset values immediately (async).

Decomposition:
- Package iot_event_pkg:
  - code constants EV_NONE=2'b00, EV_RISE=2'b01, EV_FALL=2'b10, EV_FAULT=2'b11;
  - channel IDs CH_LIGHTS=0, CH_PLUGS=1, CH_TEMP=2;
  - record field offsets/widths.
- One sub-module, event_fifo (parameterised width/depth, FWFT, full/empty/level), instantiated once.
- Capture, arbiter and timestamp stay in the top.

Test Plan:
- Single event: data=6'b000001 for one cycle, ev_ready=1 -> ev_valid=1 two edges later with ch=0, code=01, ts = value at the capture edge; level returns to 0 after the pop.
- Simultaneous events: data=6'b100110 for one cycle, rr=0 -> three records in order ch0 code10, ch1 code01, ch2 code10, all with identical ts; rr=0 at the end.
- Backpressure: ev_ready=0, ten single events spaced 3 cycles apart on ch1 -> level saturates at 8; pending[1] holds the 9th event. The 10th is dropped: drop_cnt=1, overflow=1. Raise ev_ready -> 9 records out in order, data stable while stalled.
- Collision with grant: ch2 code 11 on two consecutive cycles with an empty FIFO -> both forwarded, drop_cnt=0.
- Reset mid-stream: 5 queued, assert rst=0 mid-cycle -> ev_valid=0, level=0 and drop_cnt=0 immediately; after release, a new event emerges with ts starting from 0.
- Timestamp wrap (TS_W=4): event at ts=15 and event at next ts -> records carry ts 15 then 0.
